// File: rtl/sregs_irq_pkg.sv
// rtl/sregs_irq_pkg.sv - register indices, MODE bit positions, opcodes and FSM encoding
package sregs_irq_pkg;

    localparam logic [15:0] SR_MODE  = 16'd1;
    localparam logic [15:0] SR_JTR   = 16'd2;
    localparam logic [15:0] SR_EPC   = 16'd3;
    localparam logic [15:0] SR_MASK  = 16'd4;
    localparam logic [15:0] SR_PEND  = 16'd5;
    localparam logic [15:0] SR_CAUSE = 16'd6;
    localparam logic [15:0] SR_SMODE = 16'd7;

    localparam int MODE_SUP   = 0;
    localparam int MODE_INA   = 1;
    localparam int MODE_IRQEN = 2;

    localparam logic [2:0] MODE_RESET = 3'b001;

    localparam logic [6:0] IRET_OP_DEFAULT = 7'b0010010;
    localparam logic [6:0] OP_BOOT_A       = 7'b0001110;
    localparam logic [6:0] OP_BOOT_B       = 7'b0001111;
    localparam logic [6:0] OP_BOOT_SEL     = 7'b0010001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-first priority encoder for pending interrupt lines
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] vec_i,
    output logic [3:0]   idx_o,
    output logic         valid_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx_o   = 4'd0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = 4'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sregs_irq.sv
// rtl/sregs_irq.sv - special registers with edge-triggered interrupt controller
module sregs_irq
    import sregs_irq_pkg::*;
#(
    parameter int         NIRQ    = 4,
    parameter logic [6:0] IRET_OP = IRET_OP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sr_ie,
    input  logic [15:0]     sr_sel,
    input  logic [15:0]     sr_in,
    input  logic [6:0]      instr_op,
    output logic [15:0]     sr_out,
    input  logic [NIRQ-1:0] irq_in,
    input  logic [15:0]     pc_in,
    input  logic            pc_ie,
    input  logic            pc_inc,
    input  logic            out_addr_ovr,
    input  logic            irq_ack,
    output logic            irq_req,
    output logic            boot_mode,
    output logic            instr_mem_over,
    output logic            irq_en
);

    irq_state_e      state_q, state_d;
    logic [2:0]      mode_q, mode_d;
    logic [2:0]      smode_q, smode_d;
    logic            jtr_q, jtr_d;
    logic            boot_q, boot_d;
    logic [15:0]     epc_q, epc_d;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic [NIRQ-1:0] pend_q, pend_d;
    logic [NIRQ-1:0] prev_q;
    logic [3:0]      cause_q, cause_d;

    logic [3:0]      enc_idx;
    logic            enc_valid;
    logic            irq_cond;
    logic            ack_take;
    logic            iret_take;
    logic [NIRQ-1:0] pend_clr;
    logic [15:0]     mask_rd;
    logic [15:0]     pend_rd;

    irq_prio_enc #(.N(NIRQ)) u_prio (
        .vec_i   (pend_q & mask_q),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    assign irq_cond  = mode_q[MODE_IRQEN] & enc_valid;
    assign irq_req   = irq_cond & ((state_q == ST_IDLE) | (state_q == ST_REQ));
    assign ack_take  = (state_q == ST_REQ) & irq_ack & irq_cond;
    assign iret_take = (state_q == ST_ACTIVE) & (instr_op == IRET_OP);

    assign boot_mode      = boot_q;
    assign instr_mem_over = mode_q[MODE_INA];
    assign irq_en         = mode_q[MODE_IRQEN];

    // A nested request out of ACTIVE goes back through REQ; IRET wins if both happen together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (irq_cond) state_d = ST_REQ;
            ST_REQ: begin
                if (ack_take)       state_d = ST_ACTIVE;
                else if (!irq_cond) state_d = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (iret_take)     state_d = ST_IDLE;
                else if (irq_cond) state_d = ST_REQ;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pend_clr = '0;
        if (sr_ie && sr_sel == SR_PEND) pend_clr = sr_in[NIRQ-1:0];
        if (ack_take) begin
            for (int i = 0; i < NIRQ; i++) begin
                if (4'(i) == enc_idx) pend_clr[i] = 1'b1;
            end
        end
        // New edges take precedence over any clear in the same cycle.
        pend_d = (pend_q & ~pend_clr) | (irq_in & ~prev_q);
    end

    always_comb begin
        mode_d  = mode_q;
        smode_d = smode_q;
        jtr_d   = jtr_q;
        boot_d  = boot_q;
        epc_d   = epc_q;
        mask_d  = mask_q;
        cause_d = cause_q;

        if (sr_ie) begin
            case (sr_sel)
                SR_MODE:  if (mode_q[MODE_SUP]) mode_d = sr_in[2:0];
                SR_JTR:   jtr_d   = sr_in[0];
                SR_EPC:   epc_d   = sr_in;
                SR_MASK:  mask_d  = sr_in[NIRQ-1:0];
                SR_CAUSE: cause_d = sr_in[3:0];
                SR_SMODE: smode_d = sr_in[2:0];
                default:  ;
            endcase
        end

        if (out_addr_ovr) mode_d[MODE_IRQEN] = 1'b1;

        if (ack_take) begin
            cause_d             = enc_idx;
            smode_d             = mode_q;
            mode_d[MODE_SUP]    = 1'b1;
            mode_d[MODE_IRQEN]  = 1'b0;
            if (pc_ie)       epc_d = sr_in;
            else if (pc_inc) epc_d = pc_in + 16'd1;
            else             epc_d = pc_in;
        end

        if (iret_take) mode_d = smode_q;

        if (instr_op == OP_BOOT_A || instr_op == OP_BOOT_B ||
            (instr_op == OP_BOOT_SEL && sr_sel == 16'd0)) begin
            boot_d = jtr_q;
        end
    end

    always_comb begin
        mask_rd = '0;
        pend_rd = '0;
        mask_rd[NIRQ-1:0] = mask_q;
        pend_rd[NIRQ-1:0] = pend_q;
        sr_out = 16'd0;
        if (out_addr_ovr) begin
            sr_out = epc_q;
        end else begin
            case (sr_sel)
                SR_MODE:  sr_out = {13'd0, mode_q};
                SR_JTR:   sr_out = {15'd0, jtr_q};
                SR_EPC:   sr_out = epc_q;
                SR_MASK:  sr_out = mask_rd;
                SR_PEND:  sr_out = pend_rd;
                SR_CAUSE: sr_out = {12'd0, cause_q};
                SR_SMODE: sr_out = {13'd0, smode_q};
                default:  sr_out = 16'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_RESET;
            smode_q <= 3'd0;
            jtr_q   <= 1'b1;
            boot_q  <= 1'b1;
            epc_q   <= 16'd0;
            mask_q  <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            cause_q <= 4'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            smode_q <= smode_d;
            jtr_q   <= jtr_d;
            boot_q  <= boot_d;
            epc_q   <= epc_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            prev_q  <= irq_in;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_sregs_irq.sv
// tb/tb_sregs_irq.sv - scoreboard bench for the special-register interrupt block
module tb_sregs_irq;

    localparam logic [6:0] IRET = 7'b0010010;

    logic        clk = 1'b0;
    logic        rst;
    logic        sr_ie;
    logic [15:0] sr_sel;
    logic [15:0] sr_in;
    logic [6:0]  instr_op;
    logic [15:0] sr_out;
    logic [3:0]  irq_in;
    logic [15:0] pc_in;
    logic        pc_ie;
    logic        pc_inc;
    logic        out_addr_ovr;
    logic        irq_ack;
    logic        irq_req;
    logic        boot_mode;
    logic        instr_mem_over;
    logic        irq_en;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    sregs_irq dut (
        .clk            (clk),
        .rst            (rst),
        .sr_ie          (sr_ie),
        .sr_sel         (sr_sel),
        .sr_in          (sr_in),
        .instr_op       (instr_op),
        .sr_out         (sr_out),
        .irq_in         (irq_in),
        .pc_in          (pc_in),
        .pc_ie          (pc_ie),
        .pc_inc         (pc_inc),
        .out_addr_ovr   (out_addr_ovr),
        .irq_ack        (irq_ack),
        .irq_req        (irq_req),
        .boot_mode      (boot_mode),
        .instr_mem_over (instr_mem_over),
        .irq_en         (irq_en)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [15:0] sel, input logic [15:0] exp);
        exp_t e;
        sb.push_back('{tag, exp});
        sr_sel = sel;
        #1;
        e = sb.pop_front();
        check_eq(e.tag, sr_out, e.val);
    endtask

    task automatic sig(input string tag, input logic got, input logic exp);
        exp_t e;
        sb.push_back('{tag, {15'd0, exp}});
        #1;
        e = sb.pop_front();
        check_eq(e.tag, {15'd0, got}, e.val);
    endtask

    task automatic wr(input logic [15:0] sel, input logic [15:0] data);
        sr_ie  = 1'b1;
        sr_sel = sel;
        sr_in  = data;
        tick();
        sr_ie  = 1'b0;
        sr_in  = 16'd0;
    endtask

    initial begin
        logic [15:0] rst_exp [1:7];
        rst_exp = '{16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        rst = 1'b1; sr_ie = 1'b0; sr_sel = 16'd0; sr_in = 16'd0; instr_op = 7'd0;
        irq_in = 4'd0; pc_in = 16'd0; pc_ie = 1'b0; pc_inc = 1'b0;
        out_addr_ovr = 1'b0; irq_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;

        for (int i = 1; i <= 7; i++) rd($sformatf("rst_reg%0d", i), 16'(i), rst_exp[i]);
        rd("rst_reg9", 16'd9, 16'd0);
        sig("rst_boot", boot_mode, 1'b1);
        sig("rst_req", irq_req, 1'b0);
        sig("rst_irqen", irq_en, 1'b0);
        sig("rst_imo", instr_mem_over, 1'b0);

        // Two simultaneous edges, masked to lines 1 and 2
        wr(16'd4, 16'h0006);
        wr(16'd1, 16'h0005);
        sig("irqen_on", irq_en, 1'b1);
        irq_in = 4'b0110;
        tick();
        sig("req_idle", irq_req, 1'b1);
        tick();
        sig("req_in_req", irq_req, 1'b1);
        pc_in = 16'h00FF; pc_inc = 1'b1; irq_ack = 1'b1;
        tick();
        pc_inc = 1'b0; irq_ack = 1'b0;
        rd("ack_cause", 16'd6, 16'd1);
        rd("ack_epc", 16'd3, 16'h0100);
        rd("ack_pend", 16'd5, 16'h0004);
        rd("ack_mode", 16'd1, 16'h0001);
        rd("ack_smode", 16'd7, 16'h0005);
        sig("active_req", irq_req, 1'b0);

        instr_op = IRET;
        tick();
        instr_op = 7'd0;
        rd("iret_mode", 16'd1, 16'h0005);
        sig("iret_req", irq_req, 1'b1);
        tick();
        sig("req_line2", irq_req, 1'b1);
        wr(16'd5, 16'h0004);
        rd("w1c_pend", 16'd5, 16'h0000);
        sig("w1c_req", irq_req, 1'b0);
        tick();

        // Ack outside REQ must leave EPC and CAUSE alone
        pc_in = 16'h5555; irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        rd("stray_ack_epc", 16'd3, 16'h0100);
        rd("stray_ack_cause", 16'd6, 16'd1);

        // Held level: only the first edge sets PEND[0]
        irq_in = 4'b0111;
        tick();
        rd("lvl_set", 16'd5, 16'h0001);
        tick();
        wr(16'd5, 16'h0001);
        rd("lvl_clr", 16'd5, 16'h0000);
        for (int i = 0; i < 7; i++) tick();
        rd("lvl_hold", 16'd5, 16'h0000);

        // Edge and W1C in the same cycle: set wins
        irq_in = 4'b0101;
        tick();
        irq_in = 4'b0111;
        wr(16'd5, 16'h0002);
        rd("set_beats_clr", 16'd5, 16'h0002);
        wr(16'd5, 16'h0002);
        tick(); tick();

        // Boot-mode update from JTR buffer
        wr(16'd2, 16'h0000);
        rd("jtr_rd", 16'd2, 16'h0000);
        instr_op = 7'b0010001; sr_sel = 16'd5;
        tick();
        sig("boot_sel5", boot_mode, 1'b1);
        sr_sel = 16'd0;
        tick();
        sig("boot_sel0", boot_mode, 1'b0);
        instr_op = 7'd0;
        wr(16'd2, 16'h0001);
        instr_op = 7'b0001110;
        tick();
        instr_op = 7'd0;
        sig("boot_op0e", boot_mode, 1'b1);

        // Supervisor bit gates MODE writes
        wr(16'd1, 16'h0000);
        rd("mode_clr", 16'd1, 16'h0000);
        wr(16'd1, 16'h0007);
        rd("mode_locked", 16'd1, 16'h0000);

        out_addr_ovr = 1'b1;
        rd("ovr_epc", 16'd1, 16'h0100);
        tick();
        out_addr_ovr = 1'b0;
        rd("ovr_mode", 16'd1, 16'h0004);
        sig("ovr_irqen", irq_en, 1'b1);

        // Reset discards state; then ack beats a same-cycle SW EPC write
        irq_in = 4'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd("rst2_pend", 16'd5, 16'h0000);
        rd("rst2_mode", 16'd1, 16'h0001);
        sig("rst2_req", irq_req, 1'b0);
        wr(16'd4, 16'h0001);
        wr(16'd1, 16'h0005);
        irq_in = 4'b0001;
        tick();
        tick();
        sig("req_line0", irq_req, 1'b1);
        pc_in = 16'h1234; irq_ack = 1'b1;
        sr_ie = 1'b1; sr_sel = 16'd3; sr_in = 16'hBEEF;
        tick();
        sr_ie = 1'b0; irq_ack = 1'b0; sr_in = 16'd0;
        rd("prio_epc", 16'd3, 16'h1234);
        rd("prio_cause", 16'd6, 16'd0);
        rd("prio_pend", 16'd5, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sregs_irq.md
SREGS_IRQ -- requirements
Module: sregs_irq

Interface
REQ-001 Parameter NIRQ, default 4, number of interrupt lines (legal 1..16).
REQ-002 Parameter IRET_OP, default 7'b0010010, instr_op value that returns from interrupt.
REQ-003 Port clk input 1: single clock; all state changes on rising edge.
REQ-004 Port rst input 1: synchronous, active-high reset.
REQ-005 Port sr_ie input 1: special-register write enable.
REQ-006 Port sr_sel input 16: special-register index.
REQ-007 Port sr_in input 16: write data; also the jump target when pc_ie.
REQ-008 Port instr_op input 7: current opcode.
REQ-009 Port sr_out output 16: read data, combinational.
REQ-010 Port irq_in input NIRQ: level interrupt lines, already synchronous to clk.
REQ-011 Port pc_in input 16: current PC.
REQ-012 Port pc_ie, pc_inc input 1 each: PC load and PC increment strobes.
REQ-013 Port out_addr_ovr input 1: address-override mode.
REQ-014 Port irq_ack input 1: core has vectored this cycle.
REQ-015 Port irq_req output 1: interrupt request to core.
REQ-016 Ports boot_mode, instr_mem_over, irq_en output 1 each: MODE/JTR status.

Function
REQ-017 Register map: 1 MODE[2:0] (0 SUP, 1 INA, 2 IRQEN); 2 JTR buffer[0]; 3 EPC; 4 MASK[NIRQ-1:0]; 5 PEND (read, write-1-to-clear); 6 CAUSE[3:0]; 7 SMODE[2:0]; other indices read 0, ignore writes.
REQ-018 MODE write takes effect only when MODE[0]=1; other registers always writable when sr_ie.
REQ-019 PEND[i] sets on rising edge of irq_in[i] (irq_in[i]=1, previous sample 0); set beats same-cycle W1C clear.
REQ-020 irq_req = MODE[2] & |(PEND & MASK) & (state==IDLE or REQ), combinational from registers.
REQ-021 FSM IDLE -> REQ when irq_req condition is true; REQ -> IDLE if condition drops without ack; REQ -> ACTIVE on irq_ack.
REQ-022 On irq_ack in REQ: CAUSE <= lowest index i with PEND[i]&MASK[i]; PEND[CAUSE] cleared; SMODE <= MODE; MODE[0] <= 1; MODE[2] <= 0.
REQ-023 On irq_ack, EPC <= sr_in if pc_ie, else pc_in+1 (16-bit wrap) if pc_inc, else pc_in.
REQ-024 ACTIVE -> IDLE when instr_op==IRET_OP; MODE <= SMODE same cycle.
REQ-025 irq_ack outside REQ is ignored.
REQ-026 In ACTIVE, SW write to MODE[2]=1 re-enables nesting: FSM re-enters REQ path; nested ack overwrites EPC/SMODE/CAUSE (SW saves them first).
REQ-027 boot_mode updates from JTR buffer when instr_op is 7'b0001110 or 7'b0001111, or 7'b0010001 with sr_sel==0.
REQ-028 out_addr_ovr=1 sets MODE[2] each cycle and forces sr_out=EPC regardless of sr_sel.
REQ-029 Simultaneous SW MODE write and irq_ack: ack updates win for MODE[0] and MODE[2].
REQ-030 Priority of EPC writes: irq_ack over sr_ie write to index 3.

Reset
REQ-031 Reset: MODE=3'b001, JTR buffer=1, boot_mode=1, EPC=0, MASK=0, PEND=0, CAUSE=0, SMODE=0, edge-history=0, FSM=IDLE.
REQ-032 Outputs after reset: irq_req=0, irq_en=0, instr_mem_over=0, boot_mode=1.
REQ-033 Reset mid-REQ or ACTIVE discards pending and saved state; no request until new edge.

Structure
REQ-034 Shared package holds register-index constants, MODE bit positions, FSM state encoding, IRET_OP default.
REQ-035 One sub-module irq_prio_enc: NIRQ-bit vector -> 4-bit lowest-index and valid flag, combinational.

Verification
REQ-036 Reset then read indices 1..7 -> 1,1,0,0,0,0,0; boot_mode=1.
REQ-037 MASK=4'b0110, MODE=3'b101, edges on irq_in[1] and [2] same cycle -> irq_req=1; ack with pc_inc, pc_in=0x00FF -> CAUSE=1, EPC=0x0100, PEND=4'b0100, MODE=3'b001.
REQ-038 In ACTIVE issue IRET_OP -> MODE=3'b101, irq_req=1 again next cycle for line 2.
REQ-039 Clear MODE[0] then write MODE=3'b111 -> MODE unchanged.
REQ-040 Write JTR=0, opcode 7'b0010001 with sr_sel=5 -> boot_mode stays 1; with sr_sel=0 -> boot_mode=0.
REQ-041 Held irq_in[0]=1 over 10 cycles with PEND W1C in cycle 3 -> PEND[0] stays 0 after clear (no re-set without new edge).
